disp_out_gen: RTL and testbench

- Parametrised display output stage. Sits between the pixel FIFO (filled by the VRAM AXI reader) and the video encoder/DVI transmitter.
- Generates the FIFO read window, the VRAM read-start pulse, pixel-aligned RGB and a data-enable signal (VGA_DE), all from the external HCNT/VCNT timing counters.
- New in this generation:
  - configurable timing, colour depth and FIFO read latency;
  - DISPON is sampled once per frame, so there is no mid-frame tearing;
  - background colour is shown when the display is off or the FIFO underflows;
  - sticky underflow flag.

---
 rtl/disp_out_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_disp_out_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_out_gen.sv
// disp_out_gen: display output stage between the pixel FIFO and the video encoder.
//
// Uses the external HCNT/VCNT timing counters to generate:
//   - the FIFO read window (FIFORD);
//   - the once-per-frame VRAM read start pulse (AXISTART);
//   - pixel-aligned RGB with the data-enable (VGA_DE);
//   - a sticky FIFO underflow flag (UNDERFLOW).
// DISPON is latched once per frame at HCNT==0, VCNT==VSTART-1, so mid-frame toggles cannot
// tear the picture. When the display is off or the FIFO runs dry, BGCOLOR is shown instead.
//
// Optional build macro DISP_OUT_TESTPAT_EN adds a TESTMODE input. TESTMODE is latched
// alongside DISPON. When set, the active area shows eight vertical colour bars and
// FIFORD stays low.
//
// Ports:
//   PCK        pixel clock
//   PRST       synchronous active-high reset
//   DISPON     display enable request (frame-latched)
//   HCNT/VCNT  external horizontal / vertical counters
//   FIFORD     registered FIFO read request
//   FIFOEMPTY  FIFO empty (the FIFO ignores reads while empty)
//   FIFODATA   pixel {R,G,B}, valid FIFO_LAT cycles after the FIFORD-high cycle
//   BGCOLOR    background {R,G,B}
//   UFCLR      clears UNDERFLOW (a coincident set wins)
//   TESTMODE   colour-bar request (DISP_OUT_TESTPAT_EN builds only)
//   AXISTART   one-cycle frame read start pulse
//   VGA_R/G/B  pixel colour
//   VGA_DE     active-video enable
//   UNDERFLOW  sticky underflow flag
//
// Parameter constraints: HSTART >= FIFO_LAT+2, VSTART >= 1, 1 <= FIFO_LAT <= 4.
module disp_out_gen #(
  parameter int unsigned HPERIOD  = 800,
  parameter int unsigned HFRONT   = 16,
  parameter int unsigned HWIDTH   = 96,
  parameter int unsigned HBACK    = 48,
  parameter int unsigned VPERIOD  = 525,
  parameter int unsigned VFRONT   = 10,
  parameter int unsigned VWIDTH   = 2,
  parameter int unsigned VBACK    = 33,
  parameter int unsigned CW       = 4,
  parameter int unsigned FIFO_LAT = 2,
  parameter int unsigned CNTW     = 10
) (
  input  logic            PCK,
  input  logic            PRST,
  input  logic            DISPON,
  input  logic [CNTW-1:0] HCNT,
  input  logic [CNTW-1:0] VCNT,
  output logic            FIFORD,
  input  logic            FIFOEMPTY,
  input  logic [3*CW-1:0] FIFODATA,
  input  logic [3*CW-1:0] BGCOLOR,
  input  logic            UFCLR,
`ifdef DISP_OUT_TESTPAT_EN
  input  logic            TESTMODE,
`endif
  output logic            AXISTART,
  output logic [CW-1:0]   VGA_R,
  output logic [CW-1:0]   VGA_G,
  output logic [CW-1:0]   VGA_B,
  output logic            VGA_DE,
  output logic            UNDERFLOW
);

  localparam int unsigned HSTART = HFRONT + HWIDTH + HBACK;
  localparam int unsigned VSTART = VFRONT + VWIDTH + VBACK;
  // FIFORD leads VGA_DE by the FIFO latency, the input stage and the output register.
  localparam int unsigned LEAD   = FIFO_LAT + 2;

  localparam logic [CNTW-1:0] HSetPos   = CNTW'(HSTART - LEAD);
  localparam logic [CNTW-1:0] HClrPos   = CNTW'(HPERIOD - LEAD);
  localparam logic [CNTW-1:0] VStartPos = CNTW'(VSTART);
  localparam logic [CNTW-1:0] VLatchPos = CNTW'(VSTART - 1);
  localparam logic [CNTW-1:0] VLastPos  = CNTW'(VPERIOD - 1);

  // Frame-latched control
  logic dispon_f_q;
  logic axistart_q, axistart_d;

  // Read window
  logic act_q, act_d;
  logic fiford_q, fiford_d;

  // Alignment pipeline, stage 0 first, tail at FIFO_LAT-1
  logic [FIFO_LAT-1:0] en_pipe_q, en_pipe_d;
  logic [FIFO_LAT-1:0] on_pipe_q, on_pipe_d;
  logic [FIFO_LAT-1:0] valid_pipe_q, valid_pipe_d;

  // Output register and flags
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic            de_q, de_d;
  logic            underflow_q, underflow_d;

  logic frame_latch;
  logic line_active;
  logic tail_en, tail_on, tail_valid;
  logic test_on;

`ifdef DISP_OUT_TESTPAT_EN
  localparam int unsigned BarWidth = (HPERIOD - HSTART) / 8;
  // Floor log2 of the bar width, so that all eight bars fit in the active area.
  localparam int unsigned BarShift = $clog2(BarWidth + 1) - 1;

  logic                test_f_q;
  logic [FIFO_LAT-1:0] test_pipe_q, test_pipe_d;
  logic                tail_test;
  logic [CNTW-1:0]     bar_pos;
  logic [2:0]          bar_idx;
  logic [3*CW-1:0]     bar_rgb;

  assign test_on   = test_f_q;
  assign tail_test = test_pipe_q[FIFO_LAT-1];

  // The output register loads during the cycle before the pixel it drives.
  // Indexing with HCNT+1 therefore lines the bars up with VGA_DE, with no extra delay.
  always_comb begin
    bar_pos = HCNT + CNTW'(1) - CNTW'(HSTART);
    bar_idx = 3'(bar_pos >> BarShift);
    bar_rgb = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
  end
`else
  assign test_on = 1'b0;
`endif

  assign frame_latch = (HCNT == '0) && (VCNT == VLatchPos);
  assign line_active = (VCNT >= VStartPos) && (VCNT <= VLastPos);

  assign tail_en    = en_pipe_q[FIFO_LAT-1];
  assign tail_on    = on_pipe_q[FIFO_LAT-1];
  assign tail_valid = valid_pipe_q[FIFO_LAT-1];

  // Read window: set/clear positions, forced low outside active lines. FIFORD tracks
  // act but is gated with the latched enable at set time, so it never starts mid-line.
  always_comb begin
    act_d    = act_q;
    fiford_d = fiford_q;
    if (!line_active) begin
      act_d    = 1'b0;
      fiford_d = 1'b0;
    end else if (HCNT == HSetPos) begin
      act_d    = 1'b1;
      fiford_d = dispon_f_q & ~test_on;
    end else if (HCNT == HClrPos) begin
      act_d    = 1'b0;
      fiford_d = 1'b0;
    end
  end

  assign axistart_d = frame_latch & DISPON;

  // Each pipeline stage carries the window, the display state and whether the FIFO
  // actually served the read. The tail therefore lines up with FIFODATA.
  always_comb begin
    en_pipe_d       = '0;
    on_pipe_d       = '0;
    valid_pipe_d    = '0;
    en_pipe_d[0]    = act_q;
    on_pipe_d[0]    = dispon_f_q;
    valid_pipe_d[0] = fiford_q & ~FIFOEMPTY;
    for (int s = 1; s < FIFO_LAT; s++) begin
      en_pipe_d[s]    = en_pipe_q[s-1];
      on_pipe_d[s]    = on_pipe_q[s-1];
      valid_pipe_d[s] = valid_pipe_q[s-1];
    end
  end

`ifdef DISP_OUT_TESTPAT_EN
  always_comb begin
    test_pipe_d    = '0;
    test_pipe_d[0] = test_f_q;
    for (int s = 1; s < FIFO_LAT; s++) begin
      test_pipe_d[s] = test_pipe_q[s-1];
    end
  end
`endif

  // Output selection: bars, FIFO pixel or background inside the window, black outside.
  always_comb begin
    rgb_d = '0;
    de_d  = 1'b0;
    if (tail_en) begin
      de_d = 1'b1;
`ifdef DISP_OUT_TESTPAT_EN
      if (tail_on && tail_test) begin
        rgb_d = bar_rgb;
      end else
`endif
      if (tail_on && tail_valid) begin
        rgb_d = FIFODATA;
      end else begin
        rgb_d = BGCOLOR;
      end
    end
  end

  // A read issued while the FIFO is empty sets the flag. Set takes priority over UFCLR.
  assign underflow_d = (fiford_q & FIFOEMPTY) | (underflow_q & ~UFCLR);

  always_ff @(posedge PCK) begin
    if (PRST) begin
      dispon_f_q   <= 1'b0;
      axistart_q   <= 1'b0;
      act_q        <= 1'b0;
      fiford_q     <= 1'b0;
      en_pipe_q    <= '0;
      on_pipe_q    <= '0;
      valid_pipe_q <= '0;
      rgb_q        <= '0;
      de_q         <= 1'b0;
      underflow_q  <= 1'b0;
`ifdef DISP_OUT_TESTPAT_EN
      test_f_q     <= 1'b0;
      test_pipe_q  <= '0;
`endif
    end else begin
      if (frame_latch) begin
        dispon_f_q <= DISPON;
`ifdef DISP_OUT_TESTPAT_EN
        test_f_q   <= TESTMODE;
`endif
      end
      axistart_q   <= axistart_d;
      act_q        <= act_d;
      fiford_q     <= fiford_d;
      en_pipe_q    <= en_pipe_d;
      on_pipe_q    <= on_pipe_d;
      valid_pipe_q <= valid_pipe_d;
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      underflow_q  <= underflow_d;
`ifdef DISP_OUT_TESTPAT_EN
      test_pipe_q  <= test_pipe_d;
`endif
    end
  end

  assign FIFORD    = fiford_q;
  assign AXISTART  = axistart_q;
  assign VGA_R     = rgb_q[3*CW-1:2*CW];
  assign VGA_G     = rgb_q[2*CW-1:CW];
  assign VGA_B     = rgb_q[CW-1:0];
  assign VGA_DE    = de_q;
  assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_disp_out_gen.sv
// tb_disp_out_gen: directed bench for disp_out_gen.
// Runs two instances on the same timing counters and controls: the default build, and
// one with FIFO_LAT=3, CW=8. Each instance has its own FIFO model. Expected pixels go
// into a scoreboard when the read window is driven, and come out when VGA_DE should be high.
module tb_disp_out_gen;

  localparam int HSTART  = 160;
  localparam int HPERIOD = 800;
  localparam int VSTART  = 45;
  localparam int LAT0    = 2;
  localparam int LAT1    = 3;
  localparam logic [11:0] BG0 = 12'h00F;
  localparam logic [23:0] BG1 = 24'h1234AB;

  logic        PCK = 1'b0;
  logic        PRST, DISPON, FIFOEMPTY, UFCLR;
  logic [9:0]  HCNT, VCNT;
  logic [11:0] fdata0;
  logic [23:0] fdata1;

  logic       rd0, axi0, de0, uf0;
  logic [3:0] r0, g0, b0;
  logic       rd1, axi1, de1, uf1;
  logic [7:0] r1, g1, b1;

  always #5 PCK = ~PCK;

  disp_out_gen u_dut0 (
    .PCK(PCK), .PRST(PRST), .DISPON(DISPON), .HCNT(HCNT), .VCNT(VCNT),
    .FIFORD(rd0), .FIFOEMPTY(FIFOEMPTY), .FIFODATA(fdata0), .BGCOLOR(BG0), .UFCLR(UFCLR),
    .AXISTART(axi0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_DE(de0), .UNDERFLOW(uf0)
  );

  disp_out_gen #(.FIFO_LAT(LAT1), .CW(8)) u_dut1 (
    .PCK(PCK), .PRST(PRST), .DISPON(DISPON), .HCNT(HCNT), .VCNT(VCNT),
    .FIFORD(rd1), .FIFOEMPTY(FIFOEMPTY), .FIFODATA(fdata1), .BGCOLOR(BG1), .UFCLR(UFCLR),
    .AXISTART(axi1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_DE(de1), .UNDERFLOW(uf1)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboards and FIFO models
  logic [23:0] sb0[$];
  logic [23:0] sb1[$];
  logic [23:0] dl0[LAT0];
  logic [23:0] dl1[LAT1];
  int          fcnt[2];
  int          word_m[2];

  // Reference state
  logic frame_on, killed, axi_exp;
  logic uf_m[2];
  bit   chk_en;
  int   cnt_rd, cnt_de;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] pix(input int i, input int k);
    logic [15:0] kk;
    kk = k[15:0];
    if (i == 0) return {12'h0, kk[11:0] ^ 12'h5A5};
    return {kk[7:0], ~kk[7:0], kk[15:8] ^ 8'h3C};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at h=%0d v=%0d", tag, obs, exp, HCNT, VCNT);
    end
  endtask

  // One pixel clock: check outputs on the falling edge, then advance the reference
  // state and the FIFO models across the rising edge.
  task automatic tick(input int h, input int v);
    int          lat, lo, hi;
    logic        win, rd_exp, de_exp;
    logic [23:0] bg, exp_px, obs_px;
    logic        obs_rd, obs_de, obs_uf, obs_axi;
    logic        pop [2];
    if (h == 0) killed = 1'b0;
    @(negedge PCK);
    for (int i = 0; i < 2; i++) begin
      lat    = (i == 0) ? LAT0 : LAT1;
      lo     = HSTART - (lat + 2) + 1;
      hi     = HPERIOD - (lat + 2);
      win    = !killed && v >= VSTART && h >= lo && h <= hi;
      rd_exp = win && frame_on;
      de_exp = !killed && v >= VSTART && h >= HSTART;
      if (i == 0) begin
        bg = {12'h0, BG0};
        obs_px = {12'h0, r0, g0, b0};
        obs_rd = rd0; obs_de = de0; obs_uf = uf0; obs_axi = axi0;
      end else begin
        bg = BG1;
        obs_px = {r1, g1, b1};
        obs_rd = rd1; obs_de = de1; obs_uf = uf1; obs_axi = axi1;
      end
      exp_px = 24'h0;
      if (de_exp) begin
        if (i == 0 && sb0.size() > 0) exp_px = sb0.pop_front();
        else if (i == 1 && sb1.size() > 0) exp_px = sb1.pop_front();
        else exp_px = 'x;  // nothing queued: no DUT value can match
      end
      if (chk_en) begin
        check($sformatf("fiford%0d", i), 24'(obs_rd), 24'(rd_exp));
        check($sformatf("vga_de%0d", i), 24'(obs_de), 24'(de_exp));
        check($sformatf("rgb%0d", i), obs_px, exp_px);
        check($sformatf("axistart%0d", i), 24'(obs_axi), 24'(axi_exp));
        check($sformatf("underflow%0d", i), 24'(obs_uf), 24'(uf_m[i]));
        if (i == 0 && obs_rd) cnt_rd++;
        if (i == 0 && obs_de) cnt_de++;
      end
      pop[i] = obs_rd && !FIFOEMPTY;
      if (PRST) begin
        if (i == 0) sb0.delete(); else sb1.delete();
        if (rd_exp && !FIFOEMPTY) word_m[i]++;  // the FIFO still serves this read
        uf_m[i] = 1'b0;
      end else begin
        if (win) begin
          if (frame_on && !FIFOEMPTY) begin
            exp_px = pix(i, word_m[i]);
            word_m[i]++;
          end else begin
            exp_px = bg;
          end
          if (i == 0) sb0.push_back(exp_px); else sb1.push_back(exp_px);
        end
        uf_m[i] = (rd_exp && FIFOEMPTY) || (uf_m[i] && !UFCLR);
      end
    end
    if (PRST) begin
      frame_on = 1'b0;
      axi_exp  = 1'b0;
      killed   = 1'b1;
    end else begin
      axi_exp = (h == 0 && v == VSTART - 1) && DISPON;
      if (h == 0 && v == VSTART - 1) frame_on = DISPON;
    end
    @(posedge PCK);
    #1;
    for (int k = LAT0 - 1; k > 0; k--) dl0[k] = dl0[k-1];
    dl0[0] = pop[0] ? pix(0, fcnt[0]) : 24'h000BAD;
    if (pop[0]) fcnt[0]++;
    for (int k = LAT1 - 1; k > 0; k--) dl1[k] = dl1[k-1];
    dl1[0] = pop[1] ? pix(1, fcnt[1]) : 24'hBADBAD;
    if (pop[1]) fcnt[1]++;
    fdata0 = dl0[LAT0-1][11:0];
    fdata1 = dl1[LAT1-1];
  endtask

  // One full line at VCNT=v with optional empty burst, UFCLR pulse and reset pulse.
  // exp_rd/exp_de are the instance-0 FIFORD and VGA_DE high counts for the line.
  task automatic run_line(input int v, input int e_from, input int e_len, input int clr_at,
                          input int rst_at, input int exp_rd, input int exp_de);
    cnt_rd = 0;
    cnt_de = 0;
    for (int h = 0; h < HPERIOD; h++) begin
      HCNT      = 10'(h);
      VCNT      = 10'(v);
      FIFOEMPTY = (e_len > 0) && (h >= e_from) && (h < e_from + e_len);
      UFCLR     = (h == clr_at);
      PRST      = (h == rst_at);
      tick(h, v);
    end
    check($sformatf("rd_count_v%0d", v), 24'(cnt_rd), 24'(exp_rd));
    check($sformatf("de_count_v%0d", v), 24'(cnt_de), 24'(exp_de));
  endtask

  initial begin
    PRST = 1'b1; DISPON = 1'b0; FIFOEMPTY = 1'b0; UFCLR = 1'b0;
    HCNT = '0; VCNT = '0; fdata0 = '0; fdata1 = '0;
    frame_on = 1'b0; killed = 1'b0; axi_exp = 1'b0;
    uf_m[0] = 1'b0; uf_m[1] = 1'b0;
    fcnt[0] = 0; fcnt[1] = 0; word_m[0] = 0; word_m[1] = 0;
    for (int k = 0; k < LAT0; k++) dl0[k] = '0;
    for (int k = 0; k < LAT1; k++) dl1[k] = '0;

    // Reset: outputs are undefined before the first edge, all zero afterwards.
    chk_en = 1'b0;
    tick(0, 0);
    chk_en = 1'b1;
    tick(0, 0);
    tick(0, 0);
    PRST = 1'b0;

    // Display on: latch, then FIFO pixels in order.
    DISPON = 1'b1;
    run_line(44, -1, 0, -1, -1, 0, 0);
    run_line(45, -1, 0, -1, -1, 640, 640);
    run_line(46, -1, 0, -1, -1, 640, 640);
    // Underflow for three reads, UFCLR clear, then set and clear in the same cycle.
    run_line(47, 300, 3, -1, -1, 640, 640);
    run_line(48, -1, 0, 10, -1, 640, 640);
    run_line(49, 500, 1, 500, -1, 640, 640);
    run_line(50, -1, 0, 20, -1, 640, 640);

    // DISPON drops mid-frame: no effect until the next latch.
    DISPON = 1'b0;
    run_line(200, -1, 0, -1, -1, 640, 640);
    run_line(201, -1, 0, -1, -1, 640, 640);

    // Frame latched off: background only, no reads, empty FIFO is harmless.
    run_line(44, -1, 0, -1, -1, 0, 0);
    run_line(45, -1, 0, -1, -1, 0, 640);
    run_line(46, 300, 5, -1, -1, 0, 640);
    DISPON = 1'b1;
    run_line(100, -1, 0, -1, -1, 0, 640);

    // Back on, then reset in the middle of an active line.
    run_line(44, -1, 0, -1, -1, 0, 0);
    run_line(45, -1, 0, -1, -1, 640, 640);
    run_line(46, 350, 2, -1, 400, 244, 241);
    PRST = 1'b0;
    run_line(47, -1, 0, -1, -1, 0, 640);
    run_line(44, -1, 0, -1, -1, 0, 0);
    run_line(45, -1, 0, -1, -1, 640, 640);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
